// File: rtl/weight_stream_seq_pkg.sv
// weight_stream_seq shared types: FSM state encoding and the output beat.
// Optional build macro: WEIGHT_STREAM_CHECKSUM_EN (adds checksum port to top).
package weight_stream_pkg;

    localparam int WS_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } ws_state_t;

    typedef struct packed {
        logic [WS_DATA_W-1:0] data;
        logic                 row_last;
        logic                 tile_last;
    } ws_beat_t;

endpackage

// File: rtl/weight_stream_seq_if.sv
// Weight-load stream: valid/ready handshake plus row/tile markers.
// Ports: w_valid, w_ready, w_data, w_row_last, w_tile_last.
interface weight_stream_seq_if #(
    parameter int W = 32
);
    logic         w_valid;
    logic         w_ready;
    logic [W-1:0] w_data;
    logic         w_row_last;
    logic         w_tile_last;

    modport master (
        output w_valid,
        input  w_ready,
        output w_data,
        output w_row_last,
        output w_tile_last
    );

    modport slave (
        input  w_valid,
        output w_ready,
        input  w_data,
        input  w_row_last,
        input  w_tile_last
    );
endinterface

// File: rtl/weight_stream_seq_addr_counter.sv
// Row-major (col-first) tile address counter; holds at the last address.
// Ports: clk, reset, clear (restart at 0,0), en, row, col, last, row_end.
module ws_addr_counter #(
    parameter int ROWS = 64,
    parameter int COLS = 64,
    parameter int A    = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         en,
    output logic [A-1:0] row,
    output logic [A-1:0] col,
    output logic         last,
    output logic         row_end
);

    assign row_end = (col == A'(COLS - 1));
    assign last    = row_end && (row == A'(ROWS - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            row <= '0;
            col <= '0;
        end else if (en && !last) begin
            if (row_end) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/weight_stream_seq.sv
// Streams one ROWSxCOLS weight tile from the ROM into the array load port.
// Ports: clk, reset, start, channel, rom_channel/rom_row/rom_col, rom_data,
// w (stream master), busy, done, err, checksum (WEIGHT_STREAM_CHECKSUM_EN).
module weight_stream_seq
    import weight_stream_pkg::*;
#(
    parameter int ROWS      = 64,
    parameter int COLS      = 64,
    parameter int NUM_FILES = 10,
    parameter int W         = 32,
    parameter int A         = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [A-1:0]         channel,
    output logic [A-1:0]         rom_channel,
    output logic [A-1:0]         rom_row,
    output logic [A-1:0]         rom_col,
    input  logic [W-1:0]         rom_data,
    weight_stream_seq_if.master  w,
`ifdef WEIGHT_STREAM_CHECKSUM_EN
    output logic [W-1:0]         checksum,
`endif
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    ws_state_t state, state_n;
    ws_beat_t  beat_q;
    logic      valid_q;
    logic      load;
    logic      accept;
    logic      reject;
    logic      fin;
    logic      last;
    logic      row_end;
    logic      xfer;

    ws_addr_counter #(
        .ROWS (ROWS),
        .COLS (COLS),
        .A    (A)
    ) u_addr (
        .clk     (clk),
        .reset   (reset),
        .clear   (accept),
        .en      (load),
        .row     (rom_row),
        .col     (rom_col),
        .last    (last),
        .row_end (row_end)
    );

    assign xfer          = valid_q && w.w_ready;
    assign w.w_valid     = valid_q;
    assign w.w_data      = W'(beat_q.data);
    assign w.w_row_last  = beat_q.row_last;
    assign w.w_tile_last = beat_q.tile_last;
    assign busy          = (state != IDLE);
    assign done          = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        accept  = 1'b0;
        reject  = 1'b0;
        fin     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (channel < A'(NUM_FILES)) begin
                        accept  = 1'b1;
                        state_n = FETCH;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            FETCH: begin
                // Single-stage register: refill whenever empty or draining.
                load = !valid_q || w.w_ready;
                if (load && last) begin
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (xfer && beat_q.tile_last) begin
                    fin     = 1'b1;
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= 1'b0;
            beat_q      <= '0;
            rom_channel <= '0;
            err         <= 1'b0;
        end else begin
            err <= reject;
            if (accept) begin
                rom_channel <= channel;
            end
            if (load) begin
                beat_q.data      <= WS_DATA_W'(rom_data);
                beat_q.row_last  <= row_end;
                beat_q.tile_last <= last;
                valid_q          <= 1'b1;
            end else if (fin) begin
                valid_q <= 1'b0;
            end
        end
    end

`ifdef WEIGHT_STREAM_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset || accept) begin
            checksum <= '0;
        end else if (xfer) begin
            checksum <= checksum + w.w_data;
        end
    end
`endif

endmodule
